// File: rtl/spi_cfg_regbank.sv
// SPI-slave configuration register bank clocked by SCLK: command byte, then
// burst writes or read-back of DATA_W-bit registers, with per-register write protection.
module spi_cfg_regbank #(
    parameter int                         NUM_REGS  = 8,
    parameter int                         ADDR_W    = 4,
    parameter int                         DATA_W    = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
    parameter logic [NUM_REGS-1:0]        RO_MASK   = '0
) (
    input  logic                         SCLK,
    input  logic                         rst_n,
    input  logic                         SSEL,
    input  logic                         MOSI,
    output logic                         MISO,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr
);

    localparam int SH_W  = (DATA_W > 8) ? DATA_W : 8;
    localparam int CNT_W = ($clog2(DATA_W) > 3) ? $clog2(DATA_W) : 3;

    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_CMD,
        S_WRITE,
        S_READ
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [SH_W-2:0]     shift_q, shift_d;
    logic [ADDR_W-1:0]   ptr_q,   ptr_d;
    logic                ai_q,    ai_d;
    logic [DATA_W-1:0]   tx_q,    tx_d;
    logic                miso_q,  miso_d;
    logic                wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [SH_W-1:0]     shift_in;
    logic [DATA_W-1:0]   word;
    logic                cnt_last;
    logic [ADDR_W-1:0]   ptr_adv;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_word;
    logic                ptr_hit;
    logic                ptr_ro;
    logic                wr_word;
    logic                wr_accept;

    // Shared datapath decode used by both the next-state and output logic.
    always_comb begin
        shift_in = {shift_q, MOSI};
        word     = shift_in[DATA_W-1:0];
        cnt_last = (state_q == S_CMD) ? (cnt_q == CMD_LAST) : (cnt_q == WORD_LAST);
        if (!ai_q) begin
            ptr_adv = ptr_q;
        end else if (ptr_q == PTR_LAST) begin
            ptr_adv = '0;
        end else begin
            ptr_adv = ptr_q + 1'b1;
        end
        // The word being started is at the command's address in CMD, else the advanced pointer.
        rd_addr = (state_q == S_CMD) ? shift_in[ADDR_W-1:0] : ptr_adv;
        rd_word = '0;
        ptr_hit = 1'b0;
        ptr_ro  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_word = regs_q[i];
            end
            if (ptr_q == ADDR_W'(i)) begin
                ptr_hit = 1'b1;
                ptr_ro  = RO_MASK[i];
            end
        end
    end

    // State register.
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            state_q <= S_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (SSEL) begin
            state_d = S_CMD;
        end else if (state_q == S_CMD && cnt_last) begin
            state_d = shift_in[7] ? S_READ : S_WRITE;
        end
    end

    // Output and datapath next values.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        ai_d      = ai_q;
        tx_d      = tx_q;
        miso_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_word   = 1'b0;
        if (SSEL) begin
            cnt_d   = '0;
            shift_d = '0;
            tx_d    = '0;
        end else begin
            cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
            shift_d = shift_in[SH_W-2:0];
            case (state_q)
                S_CMD: begin
                    if (cnt_last) begin
                        ptr_d = shift_in[ADDR_W-1:0];
                        ai_d  = shift_in[6];
                        if (shift_in[7]) begin
                            miso_d = rd_word[DATA_W-1];
                            tx_d   = rd_word << 1;
                        end
                    end
                end
                S_WRITE: begin
                    if (cnt_last) begin
                        wr_word = 1'b1;
                        ptr_d   = ptr_adv;
                    end
                end
                S_READ: begin
                    if (cnt_last) begin
                        ptr_d  = ptr_adv;
                        miso_d = rd_word[DATA_W-1];
                        tx_d   = rd_word << 1;
                    end else begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = tx_q << 1;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
        wr_accept = wr_word && ptr_hit && !ptr_ro;
        wr_stb_d  = wr_accept;
        if (wr_accept) begin
            wr_addr_d = ptr_q;
        end
    end

    // NOTE: the register bank itself is reset because consumers rely on RESET_VAL after reset.
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            ai_q      <= 1'b0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            ai_q      <= ai_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_accept && ptr_q == ADDR_W'(i)) begin
                    regs_q[i] <= word;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign MISO    = miso_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Bench for spi_cfg_regbank: drives SPI frames, keeps a register model and
// scoreboards expected writes and MISO bits against what the DUT produces.
module tb_spi_cfg_regbank;

    localparam int          NUM_REGS  = 8;
    localparam int          ADDR_W    = 4;
    localparam int          DATA_W    = 8;
    localparam logic [63:0] RESET_VAL = 64'h0000_0000_0000_000A;
    localparam logic [7:0]  RO_MASK   = 8'h20;

    logic        SCLK;
    logic        rst_n;
    logic        SSEL;
    logic        MOSI;
    logic        MISO;
    logic [63:0] regs;
    logic        wr_stb;
    logic [3:0]  wr_addr;

    spi_cfg_regbank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_VAL(RESET_VAL),
        .RO_MASK  (RO_MASK)
    ) dut (
        .SCLK   (SCLK),
        .rst_n  (rst_n),
        .SSEL   (SSEL),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .regs   (regs),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t    wr_q [$];
    logic       rd_q [$];
    logic [7:0] exp_regs [NUM_REGS];
    logic [7:0] wdata [8];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_ptr(input int p, input logic ai);
        if (!ai) return p;
        if (p == NUM_REGS - 1) return 0;
        return (p + 1) & 15;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_regs[i] = RESET_VAL[i*8 +: 8];
        end
    endtask

    task automatic check_all_regs(input string tag);
        logic [63:0] img;
        for (int i = 0; i < NUM_REGS; i++) begin
            img[i*8 +: 8] = exp_regs[i];
        end
        check(tag, regs, img);
    endtask

    // Write scoreboard: every wr_stb cycle pops one expected write.
    always @(negedge SCLK) begin
        if (wr_stb === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", {60'd0, wr_addr}, 64'hFFFF);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                check("wr_addr", {60'd0, wr_addr}, {60'd0, e.addr});
                check("wr_data", {56'd0, regs[e.addr[2:0]*8 +: 8]}, {56'd0, e.data});
            end
        end
    end

    // One frame: command byte, nwords full words from wdata, then partial_bits extra bits.
    task automatic spi_frame(input logic [7:0] cmd, input int nwords, input int partial_bits,
                             input bit no_wait);
        logic rd;
        logic ai;
        int   ptr;
        rd  = cmd[7];
        ai  = cmd[6];
        ptr = int'(cmd[3:0]);
        if (!no_wait) @(negedge SCLK);
        SSEL = 1'b0;
        MOSI = cmd[7];
        for (int i = 1; i < 8; i++) begin
            @(negedge SCLK);
            MOSI = cmd[7-i];
        end
        for (int w = 0; w < nwords; w++) begin
            if (rd) begin
                logic [7:0] v;
                v = (ptr < NUM_REGS) ? exp_regs[ptr] : 8'h00;
                for (int b = 7; b >= 0; b--) rd_q.push_back(v[b]);
            end else if (ptr < NUM_REGS && !RO_MASK[ptr]) begin
                wr_q.push_back('{addr: 4'(ptr), data: wdata[w]});
                exp_regs[ptr] = wdata[w];
            end
            for (int b = 0; b < 8; b++) begin
                @(negedge SCLK);
                if (rd) begin
                    if (rd_q.size() == 0) check("miso_q_empty", 64'd0, 64'd1);
                    else check("miso_rd", {63'd0, MISO}, {63'd0, rd_q.pop_front()});
                end else begin
                    check("miso_wr", {63'd0, MISO}, 64'd0);
                end
                MOSI = wdata[w][7-b];
            end
            ptr = next_ptr(ptr, ai);
        end
        for (int b = 0; b < partial_bits; b++) begin
            @(negedge SCLK);
            MOSI = ~MOSI;
        end
        @(negedge SCLK);
        SSEL = 1'b1;
        MOSI = 1'b0;
        repeat (2) @(negedge SCLK);
        check("miso_idle", {63'd0, MISO}, 64'd0);
        check("stb_idle", {63'd0, wr_stb}, 64'd0);
        check_all_regs("regs_frame");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        SSEL  = 1'b1;
        MOSI  = 1'b0;
        model_reset();
        repeat (2) @(posedge SCLK);
        @(negedge SCLK);
        check("rst_regs", regs, RESET_VAL);
        check("rst_stb", {63'd0, wr_stb}, 64'd0);
        check("rst_miso", {63'd0, MISO}, 64'd0);
        check("rst_addr", {60'd0, wr_addr}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge SCLK);

        // Single write to reg2.
        wdata[0] = 8'h3C;
        spi_frame(8'h02, 1, 0, 0);
        check("single_reg2", {56'd0, regs[23:16]}, 64'h3C);
        check("single_addr", {60'd0, wr_addr}, 64'd2);

        // Auto-increment burst wrapping 6 -> 7 -> 0.
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
        spi_frame(8'h46, 3, 0, 0);
        check("burst_addr", {60'd0, wr_addr}, 64'd0);

        // Preload reg3/reg4, then read back with and without auto-increment.
        wdata[0] = 8'hA5; wdata[1] = 8'h5A;
        spi_frame(8'h43, 2, 0, 0);
        spi_frame(8'hC3, 2, 0, 0);
        spi_frame(8'h83, 2, 0, 0);
        spi_frame(8'hC7, 2, 0, 0);

        // Abort after 5 data bits of a write to reg1, then read reg1 back.
        wdata[0] = 8'hFF;
        spi_frame(8'h01, 0, 5, 0);
        spi_frame(8'h81, 1, 0, 0);

        // Protected register and out-of-range address.
        wdata[0] = 8'hFF;
        spi_frame(8'h05, 1, 0, 0);
        spi_frame(8'h09, 1, 0, 0);
        spi_frame(8'h89, 1, 0, 0);
        spi_frame(8'hC9, 2, 0, 0);

        // Reset mid-frame: following bits with SSEL low form a new command.
        @(negedge SCLK);
        SSEL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MOSI = 1'b1;
            @(negedge SCLK);
        end
        rst_n = 1'b0;
        @(negedge SCLK);
        model_reset();
        check("midrst_regs", regs, RESET_VAL);
        check("midrst_addr", {60'd0, wr_addr}, 64'd0);
        rst_n = 1'b1;
        wdata[0] = 8'h77;
        spi_frame(8'h01, 1, 0, 1);
        check("midrst_reg1", {56'd0, regs[15:8]}, 64'h77);

        repeat (2) @(negedge SCLK);
        check("wr_pending", 64'(wr_q.size()), 64'd0);
        check("rd_pending", 64'(rd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
